// File: rtl/dram_bw_pkg.sv
// rtl/dram_bw_pkg.sv - shared request codes, FSM states and helpers for the DRAM bandwidth tester
//
// Purpose: the request codes understood by the DRAM controller, the tester FSM
// state encoding, and a width-generic saturating increment.
// Ports: none (package).

package dram_bw_pkg;

  localparam logic [1:0] REQ_IDLE  = 2'd0;
  localparam logic [1:0] REQ_READ  = 2'd1;
  localparam logic [1:0] REQ_WRITE = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WREQ  = 3'd1,
    ST_WACK  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RREQ  = 3'd4,
    ST_RACK  = 3'd5,
    ST_READ  = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 64).
  // Callers zero-extend into 64 bits and truncate the result back.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/dram_pattern_gen.sv
// rtl/dram_pattern_gen.sv - combinational test pattern word for one DRAM element
//
// Purpose: lane j of element INDEX is SEED + INDEX*LANES + j (mod 2^32),
// lane 0 in bits [31:0].
// Ports:
//   SEED   in  32      pattern seed
//   INDEX  in  32      element index
//   WORD   out DATA_W  pattern word for that element

module dram_pattern_gen #(
  parameter int DATA_W = 512
) (
  input  logic [31:0]       SEED,
  input  logic [31:0]       INDEX,
  output logic [DATA_W-1:0] WORD
);

  localparam int LANES = DATA_W / 32;

  logic [31:0] base;

  assign base = SEED + INDEX * 32'(LANES);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign WORD[32*j +: 32] = base + 32'(j);
  end

endmodule

// File: rtl/dram_bw_tester.sv
// rtl/dram_bw_tester.sv - write/read-back bandwidth tester on the DRAM controller user port
//
// Purpose: on START writes ELEM pattern words from ADDR, reads the region back,
// checks each word against the regenerated pattern, and reports cycle counts
// and error statistics.
// Ports:
//   CLK, RST_X           user clock, asynchronous active-low reset
//   DRAM_RST             controller not ready (high)
//   START, ADDR, ELEM, SEED   test launch and parameters (latched at START)
//   D_REQ, D_INITADR, D_ELEM, D_DIN   request side towards the controller
//   D_W, D_DOUT, D_DOUTEN, D_BUSY     controller handshake and read data
//   BUSY, DONE, PASS, ERR_CNT, FIRST_ERR, WCYC, RCYC   status/results

module dram_bw_tester
  import dram_bw_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic              DRAM_RST,
  input  logic              START,
  input  logic [31:0]       ADDR,
  input  logic [31:0]       ELEM,
  input  logic [31:0]       SEED,
  output logic [1:0]        D_REQ,
  output logic [31:0]       D_INITADR,
  output logic [31:0]       D_ELEM,
  output logic [DATA_W-1:0] D_DIN,
  input  logic              D_W,
  input  logic [DATA_W-1:0] D_DOUT,
  input  logic              D_DOUTEN,
  input  logic              D_BUSY,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [CNT_W-1:0]  ERR_CNT,
  output logic [31:0]       FIRST_ERR,
  output logic [CNT_W-1:0]  WCYC,
  output logic [CNT_W-1:0]  RCYC
);

  state_t            state, state_n;
  logic [1:0]        d_req_q, d_req_n;
  logic [31:0]       addr_q, addr_n;
  logic [31:0]       elem_q, elem_n;
  logic [31:0]       seed_q, seed_n;
  logic [31:0]       wi, wi_n;
  logic [31:0]       ri, ri_n;
  logic [CNT_W-1:0]  err_q, err_n;
  logic [31:0]       first_q, first_n;
  logic [CNT_W-1:0]  wcyc_q, wcyc_n;
  logic [CNT_W-1:0]  rcyc_q, rcyc_n;
  logic              pass_q, pass_n;
  logic              active;
  logic [DATA_W-1:0] chk_word;

  dram_pattern_gen #(.DATA_W(DATA_W)) u_wr_pat (
    .SEED  (seed_q),
    .INDEX (wi),
    .WORD  (D_DIN)
  );

  dram_pattern_gen #(.DATA_W(DATA_W)) u_rd_pat (
    .SEED  (seed_q),
    .INDEX (ri),
    .WORD  (chk_word)
  );

  assign active = (state != ST_IDLE) && (state != ST_DONE);

  always_comb begin
    state_n = state;
    d_req_n = REQ_IDLE;
    addr_n  = addr_q;
    elem_n  = elem_q;
    seed_n  = seed_q;
    wi_n    = wi;
    ri_n    = ri;
    err_n   = err_q;
    first_n = first_q;
    wcyc_n  = wcyc_q;
    rcyc_n  = rcyc_q;
    pass_n  = pass_q;

    if (active && DRAM_RST) begin
      // Controller dropped out underneath us: abandon the run, keep the stats.
      state_n = ST_DONE;
      pass_n  = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START && !DRAM_RST) begin
            addr_n  = ADDR;
            elem_n  = ELEM;
            seed_n  = SEED;
            wi_n    = '0;
            ri_n    = '0;
            err_n   = '0;
            first_n = '1;
            wcyc_n  = '0;
            rcyc_n  = '0;
            pass_n  = (ELEM == '0);
            state_n = (ELEM == '0) ? ST_DONE : ST_WREQ;
          end
        end
        ST_WREQ: begin
          if (!D_BUSY) begin
            d_req_n = REQ_WRITE;
            state_n = ST_WACK;
          end
        end
        ST_WACK: begin
          wcyc_n = CNT_W'(sat_inc(64'(wcyc_q), CNT_W));
          if (D_BUSY) state_n = ST_WRITE;
        end
        ST_WRITE: begin
          wcyc_n = CNT_W'(sat_inc(64'(wcyc_q), CNT_W));
          if (D_W) wi_n = wi + 32'd1;
          if (!D_BUSY) begin
            // A write burst the controller ended early (or overran) is one error.
            if (wi_n != elem_q) err_n = CNT_W'(sat_inc(64'(err_n), CNT_W));
            state_n = ST_RREQ;
          end
        end
        ST_RREQ: begin
          if (!D_BUSY) begin
            d_req_n = REQ_READ;
            ri_n    = '0;
            state_n = ST_RACK;
          end
        end
        ST_RACK: begin
          rcyc_n = CNT_W'(sat_inc(64'(rcyc_q), CNT_W));
          if (D_BUSY) state_n = ST_READ;
        end
        ST_READ: begin
          rcyc_n = CNT_W'(sat_inc(64'(rcyc_q), CNT_W));
          // The last beat may arrive in the same cycle D_BUSY falls; it is
          // checked before the run closes.
          if (D_DOUTEN) begin
            if (D_DOUT != chk_word) begin
              err_n = CNT_W'(sat_inc(64'(err_n), CNT_W));
              if (first_q == '1) first_n = ri;
            end
            ri_n = ri + 32'd1;
          end
          if (!D_BUSY) begin
            if (ri_n != elem_q) err_n = CNT_W'(sat_inc(64'(err_n), CNT_W));
            pass_n  = (err_n == '0);
            state_n = ST_DONE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state   <= ST_IDLE;
      d_req_q <= REQ_IDLE;
      addr_q  <= '0;
      elem_q  <= '0;
      seed_q  <= '0;
      wi      <= '0;
      ri      <= '0;
      err_q   <= '0;
      first_q <= '1;
      wcyc_q  <= '0;
      rcyc_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state   <= state_n;
      d_req_q <= d_req_n;
      addr_q  <= addr_n;
      elem_q  <= elem_n;
      seed_q  <= seed_n;
      wi      <= wi_n;
      ri      <= ri_n;
      err_q   <= err_n;
      first_q <= first_n;
      wcyc_q  <= wcyc_n;
      rcyc_q  <= rcyc_n;
      pass_q  <= pass_n;
    end
  end

  assign D_REQ     = d_req_q;
  assign D_INITADR = addr_q;
  assign D_ELEM    = elem_q;
  assign BUSY      = active;
  assign DONE      = (state == ST_DONE);
  assign PASS      = pass_q;
  assign ERR_CNT   = err_q;
  assign FIRST_ERR = first_q;
  assign WCYC      = wcyc_q;
  assign RCYC      = rcyc_q;

endmodule

// File: tb/tb_dram_bw_tester.sv
// tb/tb_dram_bw_tester.sv - directed self-checking bench for dram_bw_tester

module tb_dram_bw_tester;

  localparam int DATA_W = 512;
  localparam int LANES  = DATA_W / 32;
  localparam int CNT_W  = 32;

  logic              CLK = 1'b0;
  logic              RST_X = 1'b1;
  logic              DRAM_RST = 1'b0;
  logic              START = 1'b0;
  logic [31:0]       ADDR = '0, ELEM = '0, SEED = '0;
  logic [1:0]        D_REQ;
  logic [31:0]       D_INITADR, D_ELEM;
  logic [DATA_W-1:0] D_DIN;
  logic              D_W = 1'b0;
  logic [DATA_W-1:0] D_DOUT = '0;
  logic              D_DOUTEN = 1'b0;
  logic              D_BUSY = 1'b0;
  logic              BUSY, DONE, PASS;
  logic [CNT_W-1:0]  ERR_CNT, WCYC, RCYC;
  logic [31:0]       FIRST_ERR;

  dram_bw_tester #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_X(RST_X), .DRAM_RST(DRAM_RST), .START(START),
    .ADDR(ADDR), .ELEM(ELEM), .SEED(SEED),
    .D_REQ(D_REQ), .D_INITADR(D_INITADR), .D_ELEM(D_ELEM), .D_DIN(D_DIN),
    .D_W(D_W), .D_DOUT(D_DOUT), .D_DOUTEN(D_DOUTEN), .D_BUSY(D_BUSY),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_CNT(ERR_CNT),
    .FIRST_ERR(FIRST_ERR), .WCYC(WCYC), .RCYC(RCYC)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic        chk_din = 1'b0;
  int          w_idx = 0;
  logic [31:0] m_seed = '0;
  int          req_w = 0;
  int          req_r = 0;

  // Element i, lane j holds seed + i*LANES + j.
  function automatic logic [DATA_W-1:0] model_word(input logic [31:0] seed, input int idx);
    logic [DATA_W-1:0] w;
    for (int j = 0; j < LANES; j++) w[j*32 +: 32] = seed + 32'(idx * LANES + j);
    return w;
  endfunction

  // Per-cycle compare: write data whenever the controller model consumes it,
  // and legality of the request code every cycle.
  always @(negedge CLK) begin
    if (chk_din && D_W) begin
      n_cmp++;
      if (D_DIN !== model_word(m_seed, w_idx)) begin
        n_fail++;
        $display("FAIL din[%0d]: got %h expected %h", w_idx, D_DIN, model_word(m_seed, w_idx));
      end
    end
    n_cmp++;
    if (D_REQ === 2'd3 || $isunknown(D_REQ)) begin
      n_fail++;
      $display("FAIL d_req_legal: got %b expected 0/1/2", D_REQ);
    end
    if (D_REQ === 2'd2) req_w++;
    if (D_REQ === 2'd1) req_r++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_req(input logic [1:0] code, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      if (D_REQ === code) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_d_req"},     64'(D_REQ), 64'd0);
    check({tag, "_initadr"},   64'(D_INITADR), 64'd0);
    check({tag, "_d_elem"},    64'(D_ELEM), 64'd0);
    check({tag, "_busy"},      64'(BUSY), 64'd0);
    check({tag, "_done"},      64'(DONE), 64'd0);
    check({tag, "_pass"},      64'(PASS), 64'd0);
    check({tag, "_err_cnt"},   64'(ERR_CNT), 64'd0);
    check({tag, "_first_err"}, 64'(FIRST_ERR), 64'hFFFF_FFFF);
    check({tag, "_wcyc"},      64'(WCYC), 64'd0);
    check({tag, "_rcyc"},      64'(RCYC), 64'd0);
  endtask

  task automatic do_start(input logic [31:0] addr, input logic [31:0] elem, input logic [31:0] seed);
    m_seed = seed;
    ADDR = addr; ELEM = elem; SEED = seed; START = 1'b1;
    step();
    START = 1'b0;
  endtask

  // One full write/readback with a well-behaved controller model. fa/fb are
  // read indices whose bit 0 is flipped (-1 = none).
  task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] elem,
                         input logic [31:0] seed, input int fa, input int fb,
                         input bit gaps, input bit fall, input bit abort_rd);
    int wsteps, rsteps, e_err, f_min;
    bit aborted;
    logic [DATA_W-1:0] word;
    req_w = 0; req_r = 0;
    e_err = 0; f_min = -1; aborted = 1'b0;
    if (fa >= 0 && fa < int'(elem)) begin e_err++; f_min = fa; end
    if (fb >= 0 && fb < int'(elem)) begin e_err++; if (f_min < 0 || fb < f_min) f_min = fb; end

    do_start(addr, elem, seed);
    check({tag, "_busy_start"}, 64'(BUSY), 64'd1);
    check({tag, "_initadr"}, 64'(D_INITADR), 64'(addr));
    check({tag, "_d_elem"}, 64'(D_ELEM), 64'(elem));
    wait_req(2'd2, {tag, "_wreq_seen"});

    wsteps = 0;
    step(); wsteps++;
    D_BUSY = 1'b1;
    step(); wsteps++;
    for (int i = 0; i < int'(elem); i++) begin
      w_idx = i; D_W = 1'b1; chk_din = 1'b1;
      if (seed == 32'd0 && i == 2) check({tag, "_elem2_lane3"}, 64'(D_DIN[127:96]), 64'h23);
      step(); wsteps++;
      D_W = 1'b0;
      if (gaps && (i % 2 == 1)) begin step(); wsteps++; end
    end
    chk_din = 1'b0;
    D_BUSY = 1'b0;
    step(); wsteps++;

    wait_req(2'd1, {tag, "_rreq_seen"});
    rsteps = 0;
    D_BUSY = 1'b1;
    step(); rsteps++;
    for (int i = 0; i < int'(elem) && !aborted; i++) begin
      if (abort_rd && i == 2) begin
        DRAM_RST = 1'b1;
        step();
        DRAM_RST = 1'b0;
        aborted = 1'b1;
      end else begin
        word = model_word(seed, i);
        if (i == fa || i == fb) word[0] = ~word[0];
        D_DOUT = word; D_DOUTEN = 1'b1;
        if (fall && i == int'(elem) - 1) D_BUSY = 1'b0;
        step(); rsteps++;
        D_DOUTEN = 1'b0;
      end
    end
    if (!aborted && !fall) begin
      D_BUSY = 1'b0;
      step(); rsteps++;
    end
    D_BUSY = 1'b0;

    check({tag, "_done"}, 64'(DONE), 64'd1);
    check({tag, "_busy_end"}, 64'(BUSY), 64'd0);
    check({tag, "_pass"}, 64'(PASS), 64'(!aborted && e_err == 0));
    check({tag, "_err_cnt"}, 64'(ERR_CNT), 64'(e_err));
    check({tag, "_first_err"}, 64'(FIRST_ERR), (f_min < 0) ? 64'hFFFF_FFFF : 64'(f_min));
    check({tag, "_wcyc"}, 64'(WCYC), 64'(wsteps));
    if (!aborted) check({tag, "_rcyc"}, 64'(RCYC), 64'(rsteps));
    check({tag, "_req_w_count"}, 64'(req_w), 64'd1);
    check({tag, "_req_r_count"}, 64'(req_r), 64'd1);
  endtask

  initial begin
    #1 RST_X = 1'b0;
    #1;
    check_reset_values("reset");
    repeat (3) @(posedge CLK);
    #1 RST_X = 1'b1;
    step();

    // Basic 4-element run, seed 0; hand values: WCYC = 3+4, RCYC = 2+4.
    run_txn("t4", 32'h0, 32'd4, 32'h0, -1, -1, 1'b0, 1'b0, 1'b0);
    check("t4_wcyc_hand", 64'(WCYC), 64'd7);
    check("t4_rcyc_hand", 64'(RCYC), 64'd6);

    // Bit 0 of word 5 flipped, write gaps, last beat with D_BUSY falling, seed wraps.
    run_txn("t8f", 32'h1000, 32'd8, 32'hFFFF_FFF0, 5, -1, 1'b1, 1'b1, 1'b0);
    check("t8f_first_err_hand", 64'(FIRST_ERR), 64'd5);
    check("t8f_err_hand", 64'(ERR_CNT), 64'd1);

    // Two errors: first index reported is the earliest one read.
    run_txn("t8g", 32'h2000, 32'd8, 32'h1234_5678, 6, 3, 1'b0, 1'b0, 1'b0);
    check("t8g_first_err_hand", 64'(FIRST_ERR), 64'd3);

    // ELEM = 0: straight to DONE with PASS, no request.
    req_w = 0; req_r = 0;
    do_start(32'h40, 32'd0, 32'h5);
    check("e0_done", 64'(DONE), 64'd1);
    check("e0_pass", 64'(PASS), 64'd1);
    check("e0_busy", 64'(BUSY), 64'd0);
    check("e0_d_elem", 64'(D_ELEM), 64'd0);
    repeat (4) step();
    check("e0_no_req", 64'(req_w + req_r), 64'd0);

    // Controller busy at START: no request until it goes idle, then one cycle.
    req_w = 0;
    D_BUSY = 1'b1;
    do_start(32'h80, 32'd8, 32'h9);
    for (int k = 0; k < 10; k++) begin
      check("bh_req_held", 64'(D_REQ), 64'd0);
      step();
    end
    D_BUSY = 1'b0;
    wait_req(2'd2, "bh_wreq_seen");
    step();
    check("bh_req_one_cycle", 64'(D_REQ), 64'd0);
    check("bh_req_w_count", 64'(req_w), 64'd1);
    DRAM_RST = 1'b1;
    step();
    DRAM_RST = 1'b0;
    check("bh_abort_done", 64'(DONE), 64'd1);
    check("bh_abort_pass", 64'(PASS), 64'd0);

    // Asynchronous reset in the middle of the write burst.
    do_start(32'h100, 32'd8, 32'h77);
    wait_req(2'd2, "rs_wreq_seen");
    step();
    D_BUSY = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      w_idx = i; D_W = 1'b1; chk_din = 1'b1;
      step();
      D_W = 1'b0;
    end
    chk_din = 1'b0;
    RST_X = 1'b0;
    #1;
    check_reset_values("rs_async");
    D_BUSY = 1'b0;
    step();
    RST_X = 1'b1;
    req_w = 0; req_r = 0;
    repeat (5) step();
    check("rs_no_req", 64'(req_w + req_r), 64'd0);
    check("rs_busy_idle", 64'(BUSY), 64'd0);

    run_txn("t2", 32'h300, 32'd2, 32'hABCD_0000, -1, -1, 1'b0, 1'b0, 1'b0);

    // START while the controller is still in reset is ignored.
    req_w = 0;
    DRAM_RST = 1'b1;
    do_start(32'h500, 32'd4, 32'h1);
    check("dr_busy", 64'(BUSY), 64'd0);
    check("dr_d_elem_kept", 64'(D_ELEM), 64'd2);
    check("dr_initadr_kept", 64'(D_INITADR), 64'h300);
    DRAM_RST = 1'b0;
    repeat (3) step();
    check("dr_no_req", 64'(req_w), 64'd0);

    // Controller reset raised mid-read aborts with PASS=0.
    run_txn("ab", 32'h600, 32'd6, 32'h42, -1, -1, 1'b0, 1'b0, 1'b1);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_bw_tester.md
Name: dram_bw_tester

Overview:
- User-side initiator for the DRAM controller request interface (D_REQ/D_INITADR/D_ELEM/D_DIN/D_W/D_DOUT/D_DOUTEN/D_BUSY).
- On START it performs three steps:
  - writes ELEM pattern words from ADDR;
  - issues a read request for the same region;
  - checks every returned word against the regenerated pattern.
- Reports write/read cycle counts and error statistics for the PCIe bandwidth experiments.
- Sits between the PCIe-side control registers and the DRAM controller, in the DRAM controller's user clock domain.

Parameters:
- DATA_W, 512, width of D_DIN/D_DOUT (multiple of 32).
- LANES, DATA_W/32, number of 32-bit pattern lanes (derived; not overridable).
- CNT_W, 32, width of the cycle and error counters.

Ports:
- CLK  in  1  user clock (DRAM controller USERCLK).
- RST_X  in  1  asynchronous active-low reset.
- DRAM_RST  in  1  DRAM controller RST_O, high = controller not ready.
- START  in  1  one-cycle start pulse.
- ADDR  in  32  initial DRAM address, latched at START.
- ELEM  in  32  number of DATA_W words, latched at START.
- SEED  in  32  pattern seed, latched at START.
- D_REQ  out  2  request code to DRAM controller.
- D_INITADR  out  32  latched ADDR.
- D_ELEM  out  32  latched ELEM.
- D_DIN  out  DATA_W  write data for the current element.
- D_W  in  1  controller consumed D_DIN this cycle.
- D_DOUT  in  DATA_W  read data.
- D_DOUTEN  in  1  D_DOUT valid.
- D_BUSY  in  1  controller busy.
- BUSY  out  1  tester not in IDLE/DONE.
- DONE  out  1  level; test finished, held until next START.
- PASS  out  1  valid when DONE; ERR_CNT==0.
- ERR_CNT  out  CNT_W  mismatching words, saturating.
- FIRST_ERR  out  32  index of first mismatching word; all-ones if none.
- WCYC  out  CNT_W  write-phase cycle count.
- RCYC  out  CNT_W  read-phase cycle count.

Behaviour:
- Reset (RST_X low, asynchronous) forces the following regardless of state:
  - state IDLE;
  - D_REQ=REQ_IDLE, D_INITADR=0, D_ELEM=0;
  - BUSY=0, DONE=0, PASS=0;
  - ERR_CNT=0, FIRST_ERR=all-ones, WCYC=0, RCYC=0;
  - element counters 0.
- Request codes: REQ_IDLE=2'd0, REQ_READ=2'd1, REQ_WRITE=2'd2. D_REQ is registered and non-idle for exactly one cycle per request.
- Pattern: lane j of element i is SEED + i*LANES + j, mod 2^32. Lane 0 is at bits [31:0].
- D_DIN is combinational from the write index wi and is always valid. wi increments on each cycle with D_W=1 while in WRITE.
- States:
  - IDLE/DONE:
    - START with DRAM_RST=0 latches ADDR/ELEM/SEED and clears counters, DONE and FIRST_ERR.
    - If ELEM==0, go to DONE next cycle with PASS=1 and no request issued.
    - Otherwise go to WREQ.
    - START while DRAM_RST=1 is ignored.
  - WREQ: wait for D_BUSY=0 and DRAM_RST=0, then drive D_REQ=REQ_WRITE for the next cycle and go to WACK.
  - WACK: D_REQ returns to idle; wait for D_BUSY=1, then go to WRITE.
  - WRITE: consume D_W pulses. When D_BUSY=0, go to RREQ. wi must equal ELEM at that point; otherwise count one error.
  - RREQ / RACK: same as WREQ/WACK with REQ_READ and the read index ri=0.
  - READ:
    - On each D_DOUTEN, compare D_DOUT with pattern(ri), then increment ri.
    - On mismatch, increment ERR_CNT (saturating); set FIRST_ERR=ri if it is still all-ones.
    - When D_BUSY=0, go to DONE with PASS=(ERR_CNT==0), counting a short-read error if ri!=ELEM.
- WCYC increments every cycle in WACK and WRITE; RCYC increments every cycle in RACK and READ. Both saturate.
- D_W and D_DOUTEN outside WRITE/READ are ignored.
- DRAM_RST rising in any active state aborts to DONE with PASS=0. ERR_CNT is left as is.
- A D_DOUTEN in the same cycle that D_BUSY falls is still checked before the transition.
- START while BUSY=1 is ignored.

Decomposition:
- dram_bw_pkg holds REQ_* codes, the state enum (IDLE, WREQ, WACK, WRITE, RREQ, RACK, READ, DONE), and the saturating-increment function.
- Sub-module dram_pattern_gen (parameter DATA_W; inputs SEED and index; output word) is instantiated twice: once for D_DIN and once for the checker.

Test Plan:
- ELEM=4, ADDR=0, SEED=0, controller model → 4 D_W pulses; element 2 lane 3 = 0x23; ideal readback → DONE=1, PASS=1, ERR_CNT=0, FIRST_ERR=0xFFFFFFFF, WCYC≥4.
- ELEM=0 → DONE=1, PASS=1 within 2 cycles; D_REQ never non-zero.
- ELEM=8, model flips bit 0 of read word 5 → ERR_CNT=1, FIRST_ERR=5, PASS=0.
- D_BUSY held high for 10 cycles after START → D_REQ stays 0 until D_BUSY falls, then one REQ_WRITE cycle.
- ELEM=8, RST_X low after 2 D_W pulses → all outputs at reset values immediately; no D_REQ until a new START.
- DRAM_RST=1 at START → ignored, BUSY=0; DRAM_RST raised mid-READ → DONE=1, PASS=0.
